pipeline_ctrl: RTL and testbench
================================

Name: pipeline_ctrl

Overview:
- Central stall/flush scheduler for the 5-stage CPU pipeline.
- Collects stall requests from each stage and drives the per-register stall_current_stage/stall_next_stage pairs of every PipelineDeliver-based stage register (IFID…MEMWB).
- Owns the multi-cycle multiply occupancy counter.
- Sequences exception flushes so a flush never cuts an outstanding data-bus transaction.

Parameters:
- MULT_LATENCY, 4: EX cycles a mult/multu occupies; 0 or 1 = no extra stall.
- CNT_WIDTH, 3: width of the multiply counter; must satisfy 2^CNT_WIDTH > MULT_LATENCY.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous reset, active-low.
- stall_req_if  in  1  fetch not ready (instruction bus wait).
- stall_req_id  in  1  load-use hazard.
- stall_req_ex  in  1  external EX busy (divider).
- stall_req_mem  in  1  data bus not ready.
- mult_start  in  1  EX issues mult/multu this cycle.
- exc_valid  in  1  MEM stage commits an exception this cycle.
- exc_pc  in  `ADDR_BUS  handler/EPC target.
- mem_bus_busy  in  1  data transaction outstanding.
- stall  out  6  [0]=PC, [1]=IFID, [2]=IDEX, [3]=EXMEM, [4]=MEMWB, [5]=WB commit. Register k takes stall[k] as stall_current_stage and stall[k+1] as stall_next_stage.
- flush  out  1  clear all stage registers, redirect PC.
- flush_pc  out  `ADDR_BUS  redirect target, valid with flush.
- mult_busy  out  1  multiply counter non-zero.

Behaviour:
- Reset (rst=0, async): state=IDLE, mult_cnt=0, flush=0, flush_pc=0, stall=6'b0, mult_busy=0.
- Effective EX request: req_ex = stall_req_ex | mult_busy.
- Stall vector is combinational from the requests, the registered state and the counter. Highest requesting stage k wins: stall[k:0]=1, stall[5:k+1]=0.
  - Stage indices: IF→k=1, ID→k=2, EX→k=3, MEM→k=4.
  - stall[5] is always 0.
  - No requests → stall=0.
  - A bubble is inserted at register k automatically, since stall[k]=1 and stall[k+1]=0.
- Multiply counter:
  - mult_start while mult_cnt==0, state==IDLE and MULT_LATENCY>1 → mult_cnt loads MULT_LATENCY-1 at the next edge.
  - While mult_cnt!=0: decrement by 1 only when stall[4]==0 (MEM not stalled). mult_busy=(mult_cnt!=0).
  - mult_start while busy is ignored, since EX is held.
  - Counter never wraps: decrement only when non-zero.
- Flush FSM:
  - States: IDLE, WAIT_BUS, FLUSH.
  - IDLE: exc_valid & !mem_bus_busy → FLUSH. exc_valid & mem_bus_busy → WAIT_BUS. Both arcs latch exc_pc into flush_pc.
  - WAIT_BUS: stall forced to 6'b011111. Go to FLUSH when mem_bus_busy==0. Further exc_valid is ignored (first exception wins).
  - FLUSH: flush=1 for exactly one cycle, stall forced to 0, mult_cnt cleared to 0. Go to IDLE unconditionally.
  - flush is a registered output: it goes high the cycle after acceptance (IDLE path) or the cycle after the bus drains (WAIT_BUS path).
  - exc_valid in FLUSH is ignored; the flushed MEM stage cannot raise a legitimate exception.
- Simultaneous events:
  - exc_valid and mult_start in the same IDLE cycle: exception wins; the counter is not loaded.
  - exc_valid with any stall_req: the exception is accepted; the requests only shape stall in the acceptance cycle.
- Reset mid-WAIT_BUS or mid-multiply: everything returns to reset values immediately. No flush is issued.

Decomposition:
- Shared package/define file (bus.v):
  - STALL_WIDTH=6.
  - Stage index constants STG_PC..STG_WB.
  - FSM state encodings: IDLE=2'd0, WAIT_BUS=2'd1, FLUSH=2'd2.
- One natural sub-module: mult_occupancy_cnt (load/decrement-with-enable/clear counter producing busy).
- The priority stall encoder stays inline.

Test Plan:
- Reset then idle → stall=6'b000000, flush=0, flush_pc=0. Assert stall_req_id=1 only → stall=6'b000111.
- stall_req_if=1 and stall_req_mem=1 together → stall=6'b011111. Drop mem → stall=6'b000011 the same cycle.
- mult_start pulse with MULT_LATENCY=4, no other requests → mult_busy=1 and stall=6'b001111 for exactly 3 cycles, then 0.
  - Repeat with stall_req_mem high for 2 of those cycles → busy lasts 5 cycles.
- exc_valid=1, exc_pc=32'hBFC00380, mem_bus_busy=0 → next cycle flush=1, flush_pc=32'hBFC00380, stall=0. The following cycle flush=0.
- exc_valid with mem_bus_busy=1 held 3 cycles; second exc_valid (exc_pc=32'h80000180) during the wait:
  - stall=6'b011111 while waiting.
  - flush is asserted the cycle after busy drops.
  - flush_pc=32'hBFC00380, the first exception's target.
- rst low mid-WAIT_BUS with mult_busy=1 → all outputs zero asynchronously; after release no flush pulse, mult_busy=0.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared constants for the pipeline stall/flush scheduler.
// Stage indices, stall vector width and flush FSM encodings.
package pipeline_ctrl_pkg;

    localparam int ADDR_W      = 32;
    localparam int STALL_WIDTH = 6;

    localparam int STG_PC  = 0;
    localparam int STG_IF  = 1;
    localparam int STG_ID  = 2;
    localparam int STG_EX  = 3;
    localparam int STG_MEM = 4;
    localparam int STG_WB  = 5;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_WAIT_BUS = 2'd1;
    localparam logic [1:0] ST_FLUSH    = 2'd2;

    // Hold every register up to and including stage k.
    function automatic logic [STALL_WIDTH-1:0] stall_upto(input int k);
        logic [STALL_WIDTH-1:0] m;
        m = '0;
        for (int i = 0; i < STALL_WIDTH; i++)
            m[i] = (i <= k);
        return m;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_mult_cnt.sv
// Multiply occupancy counter: load, decrement-with-enable, clear.
// busy stays high while any multiply cycles remain.
module mult_occupancy_cnt #(
    parameter int                   CNT_WIDTH = 3,
    parameter logic [CNT_WIDTH-1:0] LOAD_VAL  = '0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic dec_en,
    input  logic clr,
    output logic busy
);

    logic [CNT_WIDTH-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (load)
            cnt <= LOAD_VAL;
        else if (dec_en && cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign busy = (cnt != '0);

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush scheduler for the 5-stage pipeline.
// Priority stall encoder, multiply occupancy and exception flush FSM.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int MULT_LATENCY = 4,
    parameter int CNT_WIDTH    = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall_req_if,
    input  logic                   stall_req_id,
    input  logic                   stall_req_ex,
    input  logic                   stall_req_mem,
    input  logic                   mult_start,
    input  logic                   exc_valid,
    input  logic [ADDR_W-1:0]      exc_pc,
    input  logic                   mem_bus_busy,
    output logic [STALL_WIDTH-1:0] stall,
    output logic                   flush,
    output logic [ADDR_W-1:0]      flush_pc,
    output logic                   mult_busy
);

    localparam bit MULT_EN = (MULT_LATENCY > 1);
    localparam logic [CNT_WIDTH-1:0] LOAD_VAL =
        MULT_EN ? CNT_WIDTH'(MULT_LATENCY - 1) : '0;

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       req_ex;
    logic       exc_take;
    logic       mult_load;

    assign req_ex    = stall_req_ex | mult_busy;
    assign exc_take  = (state == ST_IDLE) && exc_valid;
    assign mult_load = MULT_EN && mult_start && !mult_busy &&
                       (state == ST_IDLE) && !exc_valid;

    always_comb begin
        stall = '0;
        if (!rst)
            stall = '0;
        else if (state == ST_FLUSH)
            stall = '0;
        else if (state == ST_WAIT_BUS)
            stall = stall_upto(STG_MEM);
        else if (stall_req_mem)
            stall = stall_upto(STG_MEM);
        else if (req_ex)
            stall = stall_upto(STG_EX);
        else if (stall_req_id)
            stall = stall_upto(STG_ID);
        else if (stall_req_if)
            stall = stall_upto(STG_IF);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:
                if (exc_valid)
                    state_nxt = mem_bus_busy ? ST_WAIT_BUS : ST_FLUSH;
            ST_WAIT_BUS:
                if (!mem_bus_busy)
                    state_nxt = ST_FLUSH;
            ST_FLUSH:
                state_nxt = ST_IDLE;
            default:
                state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            flush    <= 1'b0;
            flush_pc <= '0;
        end else begin
            state <= state_nxt;
            flush <= (state_nxt == ST_FLUSH);
            if (exc_take)
                flush_pc <= exc_pc;
        end
    end

    // Counter freezes while MEM is held so EX timing tracks the pipeline.
    mult_occupancy_cnt #(
        .CNT_WIDTH (CNT_WIDTH),
        .LOAD_VAL  (LOAD_VAL)
    ) u_mult_cnt (
        .clk    (clk),
        .rst_n  (rst),
        .load   (mult_load),
        .dec_en (!stall[STG_MEM]),
        .clr    (state == ST_FLUSH),
        .busy   (mult_busy)
    );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: directed vectors with
// hand-computed expectations checked by a negedge monitor.
module tb_pipeline_ctrl;

    logic        clk;
    logic        rst;
    logic        stall_req_if;
    logic        stall_req_id;
    logic        stall_req_ex;
    logic        stall_req_mem;
    logic        mult_start;
    logic        exc_valid;
    logic [31:0] exc_pc;
    logic        mem_bus_busy;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] flush_pc;
    logic        mult_busy;

    typedef struct {
        string       nm;
        logic [5:0]  st;
        logic        fl;
        logic [31:0] pc;
        logic        bz;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    bit   done  = 0;

    pipeline_ctrl #(.MULT_LATENCY(4), .CNT_WIDTH(3)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall_req_if  (stall_req_if),
        .stall_req_id  (stall_req_id),
        .stall_req_ex  (stall_req_ex),
        .stall_req_mem (stall_req_mem),
        .mult_start    (mult_start),
        .exc_valid     (exc_valid),
        .exc_pc        (exc_pc),
        .mem_bus_busy  (mem_bus_busy),
        .stall         (stall),
        .flush         (flush),
        .flush_pc      (flush_pc),
        .mult_busy     (mult_busy)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_o(input string nm, input logic [5:0] st,
                            input logic fl, input logic [31:0] pc,
                            input logic bz);
        exp_t e;
        e.nm = nm; e.st = st; e.fl = fl; e.pc = pc; e.bz = bz;
        q.push_back(e);
    endtask

    // Monitor: compare outputs mid-cycle against queued expectations.
    initial begin
        exp_t e;
        while (!done) begin
            @(negedge clk);
            while (q.size() > 0) begin
                e = q.pop_front();
                total++;
                if (stall !== e.st || flush !== e.fl ||
                    flush_pc !== e.pc || mult_busy !== e.bz) begin
                    bad++;
                    $display("FAIL %s: got stall=%b flush=%b pc=%h busy=%b, want stall=%b flush=%b pc=%h busy=%b",
                             e.nm, stall, flush, flush_pc, mult_busy,
                             e.st, e.fl, e.pc, e.bz);
                end
            end
        end
    end

    initial begin
        rst = 0;
        stall_req_if = 0; stall_req_id = 0;
        stall_req_ex = 0; stall_req_mem = 0;
        mult_start = 0; exc_valid = 0;
        exc_pc = '0; mem_bus_busy = 0;

        tick(); expect_o("reset", 6'b000000, 0, 32'h0, 0);
        tick(); rst = 1;
        expect_o("idle", 6'b000000, 0, 32'h0, 0);

        tick(); stall_req_id = 1;
        expect_o("id_req", 6'b000111, 0, 32'h0, 0);
        tick(); stall_req_id = 0; stall_req_if = 1; stall_req_mem = 1;
        expect_o("if_mem", 6'b011111, 0, 32'h0, 0);
        tick(); stall_req_mem = 0;
        expect_o("if_only", 6'b000011, 0, 32'h0, 0);
        tick(); stall_req_if = 0; stall_req_ex = 1;
        expect_o("ex_req", 6'b001111, 0, 32'h0, 0);
        tick(); stall_req_ex = 0;
        expect_o("no_req", 6'b000000, 0, 32'h0, 0);

        // Multiply, 3 busy cycles; a second mult_start while busy is ignored.
        tick(); mult_start = 1;
        expect_o("mul_issue", 6'b000000, 0, 32'h0, 0);
        tick(); mult_start = 0;
        expect_o("mul_b1", 6'b001111, 0, 32'h0, 1);
        tick(); mult_start = 1;
        expect_o("mul_b2", 6'b001111, 0, 32'h0, 1);
        tick(); mult_start = 0;
        expect_o("mul_b3", 6'b001111, 0, 32'h0, 1);
        tick(); expect_o("mul_end", 6'b000000, 0, 32'h0, 0);

        // Multiply with MEM stalled for 2 cycles -> 5 busy cycles.
        tick(); mult_start = 1;
        expect_o("mulm_issue", 6'b000000, 0, 32'h0, 0);
        tick(); mult_start = 0; stall_req_mem = 1;
        expect_o("mulm_b1", 6'b011111, 0, 32'h0, 1);
        tick(); expect_o("mulm_b2", 6'b011111, 0, 32'h0, 1);
        tick(); stall_req_mem = 0;
        expect_o("mulm_b3", 6'b001111, 0, 32'h0, 1);
        tick(); expect_o("mulm_b4", 6'b001111, 0, 32'h0, 1);
        tick(); expect_o("mulm_b5", 6'b001111, 0, 32'h0, 1);
        tick(); expect_o("mulm_end", 6'b000000, 0, 32'h0, 0);

        // Exception, bus idle.
        tick(); exc_valid = 1; exc_pc = 32'hBFC00380;
        expect_o("exc_acc", 6'b000000, 0, 32'h0, 0);
        tick(); exc_valid = 0;
        expect_o("exc_flush", 6'b000000, 1, 32'hBFC00380, 0);
        tick(); expect_o("exc_after", 6'b000000, 0, 32'hBFC00380, 0);

        // Exception and mult_start together: exception wins.
        tick(); exc_valid = 1; mult_start = 1; exc_pc = 32'h80000180;
        expect_o("exm_acc", 6'b000000, 0, 32'hBFC00380, 0);
        tick(); exc_valid = 0; mult_start = 0;
        expect_o("exm_flush", 6'b000000, 1, 32'h80000180, 0);
        tick(); expect_o("exm_after", 6'b000000, 0, 32'h80000180, 0);

        // Exception during bus transaction; second exception ignored.
        tick(); exc_valid = 1; exc_pc = 32'hBFC00380; mem_bus_busy = 1;
        expect_o("wb_acc", 6'b000000, 0, 32'h80000180, 0);
        tick(); exc_pc = 32'h80000180;
        expect_o("wb_w1", 6'b011111, 0, 32'hBFC00380, 0);
        tick(); exc_valid = 0;
        expect_o("wb_w2", 6'b011111, 0, 32'hBFC00380, 0);
        tick(); mem_bus_busy = 0;
        expect_o("wb_w3", 6'b011111, 0, 32'hBFC00380, 0);
        tick(); expect_o("wb_flush", 6'b000000, 1, 32'hBFC00380, 0);
        tick(); expect_o("wb_after", 6'b000000, 0, 32'hBFC00380, 0);

        // Reset while waiting on the bus with a multiply in flight.
        tick(); mult_start = 1;
        expect_o("rs_issue", 6'b000000, 0, 32'hBFC00380, 0);
        tick(); mult_start = 0; exc_valid = 1;
        exc_pc = 32'h12345678; mem_bus_busy = 1;
        expect_o("rs_acc", 6'b001111, 0, 32'hBFC00380, 1);
        tick(); exc_valid = 0;
        expect_o("rs_wait", 6'b011111, 0, 32'h12345678, 1);
        tick(); rst = 0;
        expect_o("rs_async", 6'b000000, 0, 32'h0, 0);
        tick(); rst = 1; mem_bus_busy = 0;
        expect_o("rs_rel", 6'b000000, 0, 32'h0, 0);
        tick(); expect_o("rs_nofl1", 6'b000000, 0, 32'h0, 0);
        tick(); expect_o("rs_nofl2", 6'b000000, 0, 32'h0, 0);

        for (int i = 0; i < 5 && q.size() > 0; i++)
            @(negedge clk);
        if (q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        #1;
        done = 1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
